// File: rtl/exec_ctrl_mem_unit_if.sv
// Datapath bundle between the fetch/register-file side and the decode/execute/memory slice.
// The master drives the instruction and operands; the slave returns control, ALU and memory results.
interface exec_ctrl_mem_unit_if #(
  parameter int unsigned DW = 12
);
  logic [31:0]   instrucao;
  logic [DW-1:0] data1;
  logic [DW-1:0] data2;
  logic [DW-1:0] linha;
  logic [4:0]    dbg_addr;

  logic          Branch;
  logic          MemRead;
  logic          MemtoReg;
  logic          MemWrite;
  logic          ALUSrc;
  logic          RegWrite;
  logic [1:0]    ALUOp;
  logic [3:0]    ALUcontrol;
  logic [DW-1:0] ImmGen;
  logic [DW-1:0] ALUresult;
  logic          line;
  logic [DW-1:0] sum;
  logic [DW-1:0] Writedata;
  logic [DW-1:0] dbg_data;

  modport master (
    output instrucao, data1, data2, linha, dbg_addr,
    input  Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite,
    input  ALUOp, ALUcontrol, ImmGen, ALUresult, line, sum, Writedata, dbg_data
  );

  modport slave (
    input  instrucao, data1, data2, linha, dbg_addr,
    output Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite,
    output ALUOp, ALUcontrol, ImmGen, ALUresult, line, sum, Writedata, dbg_data
  );
endinterface

// File: rtl/exec_ctrl_mem_unit.sv
// Single-cycle decode, ALU, beq resolution and data memory for a 12-bit RV32I-subset datapath.
// Everything is combinational except the data memory, which resets to mem[i] = i.
module exec_ctrl_mem_unit #(
  parameter int unsigned DW = 12,
  parameter int unsigned MD = 32
) (
  input logic                 clock,
  input logic                 reset,
  exec_ctrl_mem_unit_if.slave bus
);

  localparam int unsigned AW = $clog2(MD);

  typedef enum logic [3:0] {
    AluAnd = 4'b0000,
    AluOr  = 4'b0001,
    AluAdd = 4'b0010,
    AluXor = 4'b0011,
    AluSll = 4'b0100,
    AluSrl = 4'b0101,
    AluSub = 4'b0110
  } alu_op_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  logic [31:0]   inst;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic [31:0]   imm_i, imm_s, imm_b;

  logic          branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
  logic [1:0]    alu_op;
  alu_op_e       alu_ctrl;
  logic [DW-1:0] imm;
  logic [DW-1:0] op_b;
  logic [DW-1:0] alu_res;
  logic          take;
  logic [DW-1:0] next_line;
  logic [AW-1:0] addr;

  logic [DW-1:0] mem_q [MD];

  // rs1 field is consumed by the register file, not here
  logic unused_rs1;
  assign unused_rs1 = ^inst[19:15];

  assign inst   = bus.instrucao;
  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  // Full 32-bit sign-extended forms; the datapath keeps the low DW bits
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};

  always_comb begin
    branch     = 1'b0;
    mem_read   = 1'b0;
    mem_to_reg = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    alu_op     = 2'b00;
    alu_ctrl   = AluAdd;
    imm        = '0;
    case (opcode)
      OpLoad: begin
        mem_read   = 1'b1;
        mem_to_reg = 1'b1;
        alu_src    = 1'b1;
        reg_write  = 1'b1;
        imm        = imm_i[DW-1:0];
      end
      OpStore: begin
        mem_write = 1'b1;
        alu_src   = 1'b1;
        imm       = imm_s[DW-1:0];
      end
      OpReg: begin
        reg_write = 1'b1;
        alu_op    = 2'b10;
        case (funct3)
          3'b000:  alu_ctrl = (funct7 == 7'b0100000) ? AluSub : AluAdd;
          3'b111:  alu_ctrl = AluAnd;
          3'b110:  alu_ctrl = AluOr;
          3'b100:  alu_ctrl = AluXor;
          3'b001:  alu_ctrl = AluSll;
          3'b101:  alu_ctrl = AluSrl;
          default: alu_ctrl = AluAdd;
        endcase
      end
      OpImm: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_op    = 2'b11;
        imm       = imm_i[DW-1:0];
        case (funct3)
          3'b111:  alu_ctrl = AluAnd;
          3'b110:  alu_ctrl = AluOr;
          3'b100:  alu_ctrl = AluXor;
          default: alu_ctrl = AluAdd;
        endcase
      end
      OpBranch: begin
        branch   = 1'b1;
        alu_op   = 2'b01;
        alu_ctrl = AluSub;
        imm      = imm_b[DW-1:0];
      end
      default: ;
    endcase
  end

  assign op_b = alu_src ? imm : bus.data2;

  always_comb begin
    alu_res = '0;
    case (alu_ctrl)
      AluAnd:  alu_res = bus.data1 & op_b;
      AluOr:   alu_res = bus.data1 | op_b;
      AluAdd:  alu_res = bus.data1 + op_b;
      AluXor:  alu_res = bus.data1 ^ op_b;
      AluSll:  alu_res = bus.data1 << op_b[3:0];
      AluSrl:  alu_res = bus.data1 >> op_b[3:0];
      AluSub:  alu_res = bus.data1 - op_b;
      default: alu_res = '0;
    endcase
  end

  assign take      = branch & (bus.data1 == bus.data2);
  assign next_line = take ? bus.linha + DW'($signed(imm) >>> 2) : bus.linha + DW'(1);
  assign addr      = alu_res[AW-1:0];

  // Async reset has priority, so a store presented during reset never lands
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < MD; i++) begin
        mem_q[i] <= DW'(i);
      end
    end else if (mem_write) begin
      mem_q[addr] <= bus.data2;
    end
  end

  assign bus.Branch     = branch;
  assign bus.MemRead    = mem_read;
  assign bus.MemtoReg   = mem_to_reg;
  assign bus.MemWrite   = mem_write;
  assign bus.ALUSrc     = alu_src;
  assign bus.RegWrite   = reg_write;
  assign bus.ALUOp      = alu_op;
  assign bus.ALUcontrol = alu_ctrl;
  assign bus.ImmGen     = imm;
  assign bus.ALUresult  = alu_res;
  assign bus.line       = take;
  assign bus.sum        = next_line;
  assign bus.Writedata  = mem_to_reg ? mem_q[addr] : alu_res;
  assign bus.dbg_data   = mem_q[bus.dbg_addr];

endmodule

// File: tb/tb_exec_ctrl_mem_unit.sv
// Directed bench for exec_ctrl_mem_unit: decode, ALU, beq, memory write/read and reset reinit.
module tb_exec_ctrl_mem_unit;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_pass;

  exec_ctrl_mem_unit_if #(.DW(12)) bus ();

  exec_ctrl_mem_unit #(.DW(12), .MD(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [2:0] f3,
                                         input logic [6:0] op);
    return {imm, 5'd1, f3, 5'd3, op};
  endfunction

  function automatic logic [31:0] s_type(input logic [11:0] imm);
    return {imm[11:5], 5'd2, 5'd1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] b_type(input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd2, 5'd1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  // Inputs change in the low phase; outputs are sampled 1 time unit later
  task automatic apply(input logic [31:0] inst, input logic [11:0] d1, input logic [11:0] d2,
                       input logic [11:0] ln);
    @(negedge clock);
    bus.instrucao = inst;
    bus.data1     = d1;
    bus.data2     = d2;
    bus.linha     = ln;
    #1;
  endtask

  task automatic mem_at(input string tag, input logic [4:0] a, input logic [11:0] exp);
    bus.dbg_addr = a;
    #1;
    check(tag, {20'd0, bus.dbg_data}, {20'd0, exp});
  endtask

  function automatic logic [5:0] ctrl_bits();
    return {bus.Branch, bus.MemRead, bus.MemtoReg, bus.MemWrite, bus.ALUSrc, bus.RegWrite};
  endfunction

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    reset         = 1'b1;
    bus.instrucao = 32'h0000_0000;
    bus.data1     = '0;
    bus.data2     = '0;
    bus.linha     = '0;
    bus.dbg_addr  = '0;
    #12 reset = 1'b0;

    // Reset image
    for (int k = 0; k < 32; k++) mem_at("rst_mem", 5'(k), 12'(k));

    // add 5+7
    apply(r_type(7'b0000000, 3'b000), 12'd5, 12'd7, 12'd20);
    check("add_res", {20'd0, bus.ALUresult}, 32'd12);
    check("add_ctl", {26'd0, ctrl_bits()}, 32'b000001);
    check("add_aluop", {30'd0, bus.ALUOp}, 32'd2);
    check("add_wd", {20'd0, bus.Writedata}, 32'd12);
    check("add_sum", {20'd0, bus.sum}, 32'd21);

    // sw imm=4 at 3 -> mem[7]; old value visible until the edge
    apply(s_type(12'd4), 12'd3, 12'd99, 12'd0);
    check("sw_ctl", {26'd0, ctrl_bits()}, 32'b000110);
    check("sw_imm", {20'd0, bus.ImmGen}, 32'd4);
    check("sw_addr", {20'd0, bus.ALUresult}, 32'd7);
    mem_at("sw_before", 5'd7, 12'd7);
    @(posedge clock); #1;
    mem_at("sw_after", 5'd7, 12'd99);

    apply(i_type(12'd4, 3'b010, 7'b0000011), 12'd3, 12'd0, 12'd0);
    check("lw_ctl", {26'd0, ctrl_bits()}, 32'b011011);
    check("lw_wd", {20'd0, bus.Writedata}, 32'd99);

    // beq taken / not taken / negative offset
    apply(b_type(13'd8), 12'd9, 12'd9, 12'd10);
    check("beq_ctl", {26'd0, ctrl_bits()}, 32'b100000);
    check("beq_aluop", {28'd0, bus.ALUOp, bus.ALUcontrol}, {26'd0, 2'b01, 4'b0110});
    check("beq_line", {31'd0, bus.line}, 32'd1);
    check("beq_sum", {20'd0, bus.sum}, 32'd12);
    apply(b_type(13'd8), 12'd9, 12'd4, 12'd10);
    check("bne_line", {31'd0, bus.line}, 32'd0);
    check("bne_sum", {20'd0, bus.sum}, 32'd11);
    apply(b_type(13'h1FF8), 12'd1, 12'd1, 12'd10);
    check("bneg_imm", {20'd0, bus.ImmGen}, 32'hFF8);
    check("bneg_sum", {20'd0, bus.sum}, 32'd8);

    // ALU corner cases
    apply(r_type(7'b0100000, 3'b000), 12'd3, 12'd5, 12'd0);
    check("sub_res", {20'd0, bus.ALUresult}, 32'hFFE);
    apply(i_type(12'hFFF, 3'b000, 7'b0010011), 12'd0, 12'd0, 12'd0);
    check("addi_imm", {20'd0, bus.ImmGen}, 32'hFFF);
    check("addi_res", {20'd0, bus.ALUresult}, 32'hFFF);
    check("addi_op", {26'd0, bus.ALUOp, bus.ALUcontrol}, {26'd0, 2'b11, 4'b0010});
    apply(r_type(7'b0000000, 3'b000), 12'hFFF, 12'd1, 12'd0);
    check("add_wrap", {20'd0, bus.ALUresult}, 32'd0);
    apply(r_type(7'b0000000, 3'b001), 12'd1, 12'h013, 12'd0);
    check("sll_res", {20'd0, bus.ALUresult}, 32'd8);
    apply(r_type(7'b0000000, 3'b101), 12'hFFF, 12'd4, 12'd0);
    check("srl_res", {20'd0, bus.ALUresult}, 32'h0FF);
    apply(r_type(7'b0000000, 3'b111), 12'hF0F, 12'h0FF, 12'd0);
    check("and_res", {20'd0, bus.ALUresult}, 32'h00F);
    apply(r_type(7'b0000000, 3'b110), 12'hF0F, 12'h0FF, 12'd0);
    check("or_res", {20'd0, bus.ALUresult}, 32'hFFF);
    apply(r_type(7'b0000000, 3'b100), 12'hF0F, 12'h0FF, 12'd0);
    check("xor_res", {20'd0, bus.ALUresult}, 32'hFF0);
    apply(i_type(12'h0F0, 3'b110, 7'b0010011), 12'h00F, 12'd0, 12'd0);
    check("ori_res", {20'd0, bus.ALUresult}, 32'h0FF);

    // Address wrap and undefined opcode
    apply(i_type(12'd0, 3'b010, 7'b0000011), 12'd37, 12'd0, 12'd0);
    check("lw_wrap", {20'd0, bus.Writedata}, 32'd5);
    apply(32'h0000_007F, 12'd4, 12'd4, 12'hFFF);
    check("undef_ctl", {26'd0, ctrl_bits()}, 32'd0);
    check("undef_op", {26'd0, bus.ALUOp, bus.ALUcontrol}, {26'd0, 2'b00, 4'b0010});
    check("undef_imm", {20'd0, bus.ImmGen}, 32'd0);
    check("undef_sum", {20'd0, bus.sum}, 32'd0);

    // Store, then reset before the load
    apply(s_type(12'd0), 12'd9, 12'd55, 12'd0);
    @(posedge clock); #1;
    mem_at("sw9", 5'd9, 12'd55);
    reset = 1'b1;
    #1;
    mem_at("rst_mid", 5'd9, 12'd9);
    apply(s_type(12'd0), 12'd10, 12'd66, 12'd0);
    @(posedge clock); #1;
    mem_at("rst_blk", 5'd10, 12'd10);
    @(negedge clock);
    reset = 1'b0;
    apply(i_type(12'd0, 3'b010, 7'b0000011), 12'd9, 12'd0, 12'd0);
    check("lw_after_rst", {20'd0, bus.Writedata}, 32'd9);
    mem_at("rst_mem7", 5'd7, 12'd7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
